// File: rtl/incdec_scan_ctrl.sv
// rtl/incdec_scan_ctrl.sv - 4-digit BCD run/stop/load counter driving a multiplexed active-low 7-segment display
// Optional `BLANK_LZ_EN: blank leading-zero digits (digit 0 is always shown).
module incdec_scan_ctrl #(
  parameter int TICK_DIV = 12000000,
  parameter int SCAN_DIV = 12000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        running,
  output logic        wrap,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    dig_q, dig_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          blank;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Counter/FSM: load overrides stop/start and any coincident tick.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = bcd_clamp(load_val);
      pre_d   = '0;
    end else if (state_q == RUN) begin
      if (stop) begin
        state_d = IDLE;
        pre_d   = '0;
      end else if (pre_q == PRE_MAX) begin
        pre_d   = '0;
        count_d = bcd_inc(count_q);
        wrap_d  = (count_q == 16'h9999);
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end else if (start && !stop) begin
      state_d = RUN;
      pre_d   = '0;
    end
  end

  // Scan: an and seg are both computed from the next digit index so they switch together.
  always_comb begin
    scan_d = scan_q;
    dig_d  = dig_q;
    an_d   = an_q;
    seg_d  = seg_q;
    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
      dig_d  = dig_q + 2'd1;
      an_d   = ~(4'b0001 << dig_d);
      seg_d  = blank ? 7'h7F : glyph(count_q[4*dig_d +: 4]);
    end else begin
      scan_d = scan_q + 1'b1;
    end
  end

`ifdef BLANK_LZ_EN
  assign blank = (dig_d != 2'd0) && ((count_q >> (4 * dig_d)) == 16'd0);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      count_q <= 16'h0000;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      dig_q   <= 2'd0;
      seg_q   <= 7'h40;
      an_q    <= 4'b1110;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign count   = count_q;
  assign running = (state_q == RUN);
  assign wrap    = wrap_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule
